// File: rtl/tx_eq_pkg.sv
// Shared definitions for the TX equaliser training controller: FSM states,
// PRBS7 seed/taps and a counter-width helper.
package tx_eq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        TRAIN,
        WAIT_ERR,
        EVAL,
        APPLY,
        LOCK
    } state_e;

    localparam logic [6:0] PRBS7_SEED  = 7'h7F;
    // x^7 + x^6 + 1 feeds back from the top two register bits
    localparam int         PRBS7_TAP_A = 6;
    localparam int         PRBS7_TAP_B = 5;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prbs7_gen.sv
// Fibonacci PRBS7 generator; out is the register MSB, load reseeds, en advances.
module prbs7_gen
    import tx_eq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic out
);

    logic [6:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load)
            lfsr_d = PRBS7_SEED;
        else if (en)
            lfsr_d = {lfsr_q[5:0], lfsr_q[PRBS7_TAP_A] ^ lfsr_q[PRBS7_TAP_B]};
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= PRBS7_SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign out = lfsr_q[6];

endmodule

// File: rtl/tx_eq_train_ctrl.sv
// Sweeps the post-cursor tap code, trains each code with PRBS7, collects the
// remote error count and locks the driver to the lowest-error code.
module tx_eq_train_ctrl
    import tx_eq_pkg::*;
#(
    parameter int TAP_W      = 4,
    parameter int TAP_MAX    = 15,
    parameter int SETTLE_CYC = 16,
    parameter int TRAIN_LEN  = 1024,
    parameter int TIMEOUT    = 4096,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             data_in,
    input  logic             err_valid,
    input  logic [ERR_W-1:0] err_cnt,
    output logic             tx_en,
    output logic             tx_data,
    output logic [TAP_W-1:0] tap1_code,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] best_err
);

    localparam int SET_W = cnt_w(SETTLE_CYC);
    localparam int TRN_W = cnt_w(TRAIN_LEN);
    localparam int TO_W  = cnt_w(TIMEOUT);

    state_e             state_q, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d, best_code_q, best_code_d;
    logic [ERR_W-1:0]   best_err_q, best_err_d, err_lat_q, err_lat_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [TRN_W-1:0]   train_cnt_q, train_cnt_d;
    logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic               tx_en_q, tx_en_d, tx_data_q, tx_data_d;
    logic               sweep_go, prbs_out;

    assign sweep_go = start && (state_q == IDLE || state_q == LOCK);

    prbs7_gen u_prbs (
        .clk  (clk),
        .rst  (rst),
        .load (sweep_go),
        .en   (state_q == TRAIN),
        .out  (prbs_out)
    );

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        best_code_d  = best_code_q;
        best_err_d   = best_err_q;
        err_lat_d    = err_lat_q;
        settle_cnt_d = settle_cnt_q;
        train_cnt_d  = train_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        tx_en_d      = tx_en_q;
        case (state_q)
            IDLE, LOCK: begin
                if (start) begin
                    state_d      = SETTLE;
                    tap_d        = '0;
                    best_err_d   = '1;
                    best_code_d  = '0;
                    tx_en_d      = 1'b1;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
                    state_d      = TRAIN;
                    settle_cnt_d = '0;
                    train_cnt_d  = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            TRAIN: begin
                if (train_cnt_q == TRN_W'(TRAIN_LEN - 1)) begin
                    state_d     = WAIT_ERR;
                    train_cnt_d = '0;
                    wait_cnt_d  = '0;
                end else begin
                    train_cnt_d = train_cnt_q + TRN_W'(1);
                end
            end
            WAIT_ERR: begin
                if (err_valid) begin
                    state_d    = EVAL;
                    err_lat_d  = err_cnt;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // a silent partner scores worst so it never wins
                    state_d    = EVAL;
                    err_lat_d  = '1;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            EVAL: begin
                if (err_lat_q < best_err_q) begin
                    best_err_d  = err_lat_q;
                    best_code_d = tap_q;
                end
                if (tap_q == TAP_W'(TAP_MAX)) begin
                    state_d = APPLY;
                end else begin
                    tap_d        = tap_q + TAP_W'(1);
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end
            end
            APPLY: begin
                tap_d   = best_code_q;
                state_d = LOCK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_data_d = 1'b0;
        if (state_q == LOCK)
            tx_data_d = data_in;
        else if (state_q != IDLE)
            tx_data_d = prbs_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tap_q        <= '0;
            best_code_q  <= '0;
            best_err_q   <= '1;
            err_lat_q    <= '0;
            settle_cnt_q <= '0;
            train_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            tx_en_q      <= 1'b0;
            tx_data_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            best_code_q  <= best_code_d;
            best_err_q   <= best_err_d;
            err_lat_q    <= err_lat_d;
            settle_cnt_q <= settle_cnt_d;
            train_cnt_q  <= train_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            tx_en_q      <= tx_en_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign tx_en     = tx_en_q;
    assign tx_data   = tx_data_q;
    assign tap1_code = tap_q;
    assign best_err  = best_err_q;
    assign busy      = state_q inside {SETTLE, TRAIN, WAIT_ERR, EVAL, APPLY};
    assign done      = (state_q == LOCK);

endmodule

// File: tb/tb_tx_eq_train_ctrl.sv
// Bench for tx_eq_train_ctrl: a timeline model derived from the responder
// schedule predicts every output each cycle; literal pins anchor the model.
module tb_tx_eq_train_ctrl;

    localparam int TAP_W = 4;
    localparam int TAP_MAX = 3;
    localparam int S = 4;
    localparam int T = 160;
    localparam int TO = 50;
    localparam int ERR_W = 16;
    localparam int ALL1 = 65535;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, data_in = 1'b0, err_valid = 1'b0;
    logic [ERR_W-1:0] err_cnt = '0;
    logic tx_en, tx_data, busy, done;
    logic [TAP_W-1:0] tap1_code;
    logic [ERR_W-1:0] best_err;

    tx_eq_train_ctrl #(
        .TAP_W(TAP_W), .TAP_MAX(TAP_MAX), .SETTLE_CYC(S),
        .TRAIN_LEN(T), .TIMEOUT(TO), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .err_valid(err_valid), .err_cnt(err_cnt), .tx_en(tx_en),
        .tx_data(tx_data), .tap1_code(tap1_code), .busy(busy),
        .done(done), .best_err(best_err)
    );

    always #5 clk = ~clk;

    int cyc = 0, t0 = 0, mode = 0, errs = 0, checks = 0, lock_pos = 0;
    int resp_v[0:TAP_MAX];
    int resp_r[0:TAP_MAX];   // reply delay into WAIT_ERR, -1 = never reply
    bit ref_b[0:126];

    typedef struct {
        bit busy;
        bit done;
        int tap;
        int best;
        int code;
        int off;
    } exp_t;

    // Walk the sweep as a list of per-code segments of known length.
    function automatic exp_t model(input int pos);
        exp_t e;
        int p, best, bc, w, len, score;
        p = pos; best = ALL1; bc = 0;
        e.busy = 1'b1; e.done = 1'b0; e.code = -1; e.off = -1; e.tap = 0; e.best = ALL1;
        for (int c = 0; c <= TAP_MAX; c++) begin
            w   = (resp_r[c] < 0) ? TO : resp_r[c] + 1;
            len = S + T + w + 1;
            if (p < len) begin
                e.tap = c; e.best = best; e.code = c; e.off = p;
                return e;
            end
            p -= len;
            score = (resp_r[c] < 0) ? ALL1 : resp_v[c];
            if (score < best) begin best = score; bc = c; end
        end
        e.best = best;
        if (p == 0) e.tap = TAP_MAX;
        else begin e.busy = 1'b0; e.done = 1'b1; e.tap = bc; end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always begin : compare
        int pos, k;
        exp_t e, ep;
        @(posedge clk);
        #1;
        cyc++;
        if (mode == 0) begin
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
            chk("idle_tap", int'(tap1_code), 0);
            chk("idle_best", int'(best_err), ALL1);
            chk("idle_tx_en", int'(tx_en), 0);
            chk("idle_tx_data", int'(tx_data), 0);
        end else begin
            pos = cyc - t0;
            e = model(pos);
            chk("busy", int'(busy), int'(e.busy));
            chk("done", int'(done), int'(e.done));
            chk("tap1_code", int'(tap1_code), e.tap);
            chk("best_err", int'(best_err), e.best);
            chk("tx_en", int'(tx_en), 1);
            if (pos > 0) begin
                ep = model(pos - 1);
                if (ep.done) begin
                    chk("tx_data_lock", int'(tx_data), int'(data_in));
                end else if (ep.off >= 0 && ep.off < S + T) begin
                    k = (ep.off < S) ? 0 : ep.off - S;
                    chk("tx_data_prbs", int'(tx_data), int'(ref_b[(ep.code * T + k) % 127]));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            data_in = 1'($urandom_range(0, 1));
        end
    end

    task automatic goto_pos(input int p);
        while (cyc - t0 < p) @(negedge clk);
    endtask

    task automatic sweep(input int va, input int vb, input int vc, input int vd,
                         input int ra, input int rb, input int rc, input int rd,
                         input bit inject, input bit abort_it);
        int base, w;
        @(negedge clk);
        resp_v[0] = va; resp_v[1] = vb; resp_v[2] = vc; resp_v[3] = vd;
        resp_r[0] = ra; resp_r[1] = rb; resp_r[2] = rc; resp_r[3] = rd;
        t0 = cyc + 1; mode = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (abort_it) begin
            goto_pos(S + 30);
            rst = 1'b1; mode = 0;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        base = 0;
        for (int c = 0; c <= TAP_MAX; c++) begin
            if (inject && c == 1) begin
                goto_pos(base + S + 10);
                start = 1'b1; err_valid = 1'b1; err_cnt = '0;
                @(negedge clk);
                start = 1'b0; err_valid = 1'b0;
            end
            if (resp_r[c] >= 0) begin
                goto_pos(base + S + T + resp_r[c]);
                err_valid = 1'b1; err_cnt = ERR_W'(resp_v[c]);
                @(negedge clk);
                err_valid = 1'b0;
                w = resp_r[c] + 1;
            end else begin
                w = TO;
            end
            base += S + T + w + 1;
        end
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        chk("done_reached", int'(done), 1);
        lock_pos = cyc - t0;
    endtask

    initial begin
        int pin;
        for (int i = 0; i < 7; i++) ref_b[i] = 1'b1;
        for (int i = 7; i < 127; i++) ref_b[i] = ref_b[i-7] ^ ref_b[i-6];
        pin = 0;
        for (int i = 0; i < 14; i++) pin = (pin << 1) | int'(ref_b[i]);
        chk("prbs_ref_pin", pin, 'h3F81);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        sweep(40, 12, 12, 30, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("s1_best_err", int'(best_err), 12);
        chk("s1_tap1", int'(tap1_code), 1);
        chk("s1_lock_cycle", lock_pos, 665);
        repeat (5) @(negedge clk);

        sweep(0, 5, 5, 5, -1, 2, 0, 1, 1'b0, 1'b0);
        chk("s2_best_err", int'(best_err), 5);
        chk("s2_tap1", int'(tap1_code), 1);
        chk("s2_lock_cycle", lock_pos, 717);
        repeat (5) @(negedge clk);

        sweep(20, 20, 7, 9, 0, 3, 0, 0, 1'b1, 1'b0);
        chk("s3_best_err", int'(best_err), 7);
        chk("s3_tap1", int'(tap1_code), 2);
        repeat (5) @(negedge clk);

        sweep(1, 1, 1, 1, 0, 0, 0, 0, 1'b0, 1'b1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_best", int'(best_err), ALL1);
        chk("abort_tx_en", int'(tx_en), 0);
        repeat (3) @(negedge clk);

        sweep(9, 3, 3, 1, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("s5_best_err", int'(best_err), 1);
        chk("s5_tap1", int'(tap1_code), 3);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tx_eq_train_ctrl.md
TX_EQ_TRAIN_CTRL -- requirements
Module: tx_eq_train_ctrl

Interface
REQ-001 SHALL have parameter TAP_W, default 4: width of the post-cursor (wtap1) code.
REQ-002 SHALL have parameter TAP_MAX, default 15: last code swept; first code is 0.
REQ-003 SHALL have parameter SETTLE_CYC, default 16: cycles held after each code change before training.
REQ-004 SHALL have parameter TRAIN_LEN, default 1024: PRBS cycles sent per code.
REQ-005 SHALL have parameter TIMEOUT, default 4096: maximum cycles spent waiting for error feedback.
REQ-006 SHALL have parameter ERR_W, default 16: error-count width.
REQ-007 clk  input  1  TX clock; the only clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 start  input  1  single-cycle pulse that begins a training sweep.
REQ-010 data_in  input  1  mission-mode TX data.
REQ-011 err_valid  input  1  single-cycle pulse qualifying err_cnt.
REQ-012 err_cnt  input  ERR_W  remote error count for the code just trained.
REQ-013 tx_en  output  1  driver enable.
REQ-014 tx_data  output  1  bit presented to the driver: PRBS7 or data_in.
REQ-015 tap1_code  output  TAP_W  de-emphasis code applied to the driver.
REQ-016 busy  output  1  high while sweeping.
REQ-017 done  output  1  high once the best code is applied; cleared by start or rst.
REQ-018 best_err  output  ERR_W  lowest error count found in the sweep.

Function
REQ-019 FSM states SHALL be IDLE, SETTLE, TRAIN, WAIT_ERR, EVAL, APPLY and LOCK.
REQ-020 IDLE: start=1 -> SETTLE; at the same time tap1_code=0, best_err=all-ones, best_code=0, tx_en=1, done=0.
REQ-021 SETTLE SHALL last exactly SETTLE_CYC cycles, with tx_data=PRBS7 and a frozen tap1_code, then go to TRAIN.
REQ-022 TRAIN SHALL last exactly TRAIN_LEN cycles, with the PRBS7 generator advancing one bit per cycle, then go to WAIT_ERR.
REQ-023 WAIT_ERR: err_valid=1 -> EVAL with err_cnt latched. If TIMEOUT cycles elapse without err_valid -> EVAL with the latched value = all-ones.
REQ-024 err_valid SHALL be ignored in every state except WAIT_ERR.
REQ-025 EVAL (1 cycle):
- If latched < best_err: update best_err and best_code.
- On a tie, keep the lower code.
- If tap1_code == TAP_MAX -> APPLY; else tap1_code += 1 -> SETTLE.
REQ-026 APPLY (1 cycle): tap1_code = best_code -> LOCK.
REQ-027 LOCK: done=1, busy=0, tx_data=data_in, tx_en=1; start=1 SHALL begin a new sweep (as from IDLE).
REQ-028 busy SHALL be 1 in SETTLE, TRAIN, WAIT_ERR, EVAL and APPLY, and 0 otherwise.
REQ-029 start during busy SHALL be ignored.
REQ-030 PRBS7 SHALL use polynomial x^7+x^6+1 with seed 7'h7F, reseeded on every start; tx_data is the generator MSB, registered (1-cycle latency).
REQ-031 Counters SHALL be sized by $clog2 of their respective limits, with no wrap beyond the limit.
REQ-032 tap1_code SHALL change only in IDLE->SETTLE, EVAL and APPLY.

Reset
REQ-033 rst=1 SHALL force, at the next clk edge:
- state=IDLE, tx_en=0, tx_data=0, tap1_code=0, busy=0, done=0
- best_err=all-ones, all counters=0, PRBS state=7'h7F.
REQ-034 rst SHALL take priority over start and err_valid; rst mid-sweep SHALL abort the sweep with no partial result retained.

Structure
REQ-035 A shared package tx_eq_pkg SHALL hold the FSM state enum, the PRBS7 seed constant and the polynomial tap positions.
REQ-036 The PRBS generator SHALL be a sub-module prbs7_gen (ports clk, rst, load, en, out).
REQ-037 tap1_code SHALL drive the real-valued FIR driver weight through the codebase's existing code-to-weight converter; that conversion is outside this block.

Verification
REQ-038 Full sweep, TAP_MAX=3, err_cnt responses 40,12,12,30 -> best_code=1, best_err=12, done=1, tap1_code=1.
REQ-039 Timeout: no err_valid for code 0, err 5 for codes 1..TAP_MAX -> code 0 scored 0xFFFF; best_code=1.
REQ-040 Cycle count: start at cycle t, responder replies 1 cycle after entering WAIT_ERR -> SETTLE entered at t+1, TRAIN at t+1+SETTLE_CYC, WAIT_ERR at t+1+SETTLE_CYC+TRAIN_LEN.
REQ-041 start repeated while busy, and err_valid pulsed during TRAIN -> no effect on the sweep or on best_err.
REQ-042 rst asserted mid-TRAIN -> next cycle all outputs at reset values; a following start runs a clean sweep.
REQ-043 PRBS check: first 127 tx_data bits after SETTLE match the PRBS7 reference sequence from seed 7'h7F; in LOCK, tx_data follows data_in one cycle later.
